// File: rtl/tile_painter.sv
`default_nettype none
// ============================================================================
// Module   : tile_painter
// Purpose  : Draws one map tile as a solid RGB565 block over an 8080-style
//            8-bit LCD write bus, then pulses cmd_done back to the scanner.
// Revision : 1.0 - initial release
// ============================================================================
module tile_painter #(
    parameter int TILE_PX = 20
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       diff,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] obj_code,
    output logic       cmd_done,
    output logic       busy,
    output logic       lcd_csx,
    output logic       lcd_dcx,
    output logic       lcd_wrx,
    output logic [7:0] lcd_dat
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR_LO = 2'd1;
    localparam logic [1:0] S_WR_HI = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int         c_npix     = TILE_PX * TILE_PX;
    localparam int         c_pw       = (c_npix > 1) ? $clog2(c_npix) : 1;
    localparam logic [c_pw-1:0] c_pix_last = c_pw'(c_npix - 1);
    localparam logic [15:0] c_tile    = 16'(TILE_PX);
    // Header index 11 marks the pixel section of the byte stream.
    localparam logic [3:0] c_hdr_pix  = 4'd11;
    localparam logic [3:0] c_max_row  = 4'd11;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [3:0]      r_x;
    logic [3:0]      r_y;
    logic [15:0]     r_color;
    logic [3:0]      r_hdr;
    logic [c_pw-1:0] r_pix;
    logic            r_phase;

    logic [15:0]     w_pal;
    logic [15:0]     w_xs;
    logic [15:0]     w_xe;
    logic [15:0]     w_ys;
    logic [15:0]     w_ye;
    logic [7:0]      w_byte;
    logic            w_dcx;
    logic            w_last;
    logic            w_accept;

    assign w_accept = (r_state == S_IDLE) && diff;
    assign w_last   = (r_hdr == c_hdr_pix) && (r_pix == c_pix_last) && r_phase;

    always_comb begin
        w_pal = 16'hFFFF;
        case (obj_code)
            3'd0:    w_pal = 16'h0000;
            3'd1:    w_pal = 16'h07E0;
            3'd2:    w_pal = 16'h03E0;
            3'd3:    w_pal = 16'hF800;
            3'd4:    w_pal = 16'h001F;
            default: w_pal = 16'hFFFF;
        endcase
    end

    assign w_xs = {12'd0, r_x} * c_tile;
    assign w_xe = w_xs + c_tile - 16'd1;
    assign w_ys = {12'd0, r_y} * c_tile;
    assign w_ye = w_ys + c_tile - 16'd1;

    always_comb begin
        w_byte = 8'h00;
        case (r_hdr)
            4'd0:    w_byte = 8'h2A;
            4'd1:    w_byte = w_xs[15:8];
            4'd2:    w_byte = w_xs[7:0];
            4'd3:    w_byte = w_xe[15:8];
            4'd4:    w_byte = w_xe[7:0];
            4'd5:    w_byte = 8'h2B;
            4'd6:    w_byte = w_ys[15:8];
            4'd7:    w_byte = w_ys[7:0];
            4'd8:    w_byte = w_ye[15:8];
            4'd9:    w_byte = w_ye[7:0];
            4'd10:   w_byte = 8'h2C;
            default: w_byte = r_phase ? r_color[7:0] : r_color[15:8];
        endcase
    end

    assign w_dcx = !((r_hdr == 4'd0) || (r_hdr == 4'd5) || (r_hdr == 4'd10));

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (diff) begin
                    w_next = (y > c_max_row) ? S_DONE : S_WR_LO;
                end
            end
            S_WR_LO: w_next = S_WR_HI;
            S_WR_HI: w_next = w_last ? S_DONE : S_WR_LO;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch and byte-stream position; advances once per WR_HI cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_x     <= 4'd0;
            r_y     <= 4'd0;
            r_color <= 16'h0000;
            r_hdr   <= 4'd0;
            r_pix   <= '0;
            r_phase <= 1'b0;
        end else if (w_accept) begin
            r_x     <= x;
            r_y     <= y;
            r_color <= w_pal;
            r_hdr   <= 4'd0;
            r_pix   <= '0;
            r_phase <= 1'b0;
        end else if ((r_state == S_WR_HI) && !w_last) begin
            if (r_hdr != c_hdr_pix) begin
                r_hdr <= r_hdr + 4'd1;
            end else if (!r_phase) begin
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
                r_pix   <= r_pix + 1'b1;
            end
        end
    end

    // Output decode; bus data only moves when the counters move on WR_LO entry.
    always_comb begin
        lcd_csx  = 1'b1;
        lcd_wrx  = 1'b1;
        lcd_dcx  = 1'b1;
        lcd_dat  = 8'h00;
        cmd_done = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_WR_LO: begin
                lcd_csx = 1'b0;
                lcd_wrx = 1'b0;
                lcd_dcx = w_dcx;
                lcd_dat = w_byte;
                busy    = 1'b1;
            end
            S_WR_HI: begin
                lcd_csx = 1'b0;
                lcd_dcx = w_dcx;
                lcd_dat = w_byte;
                busy    = 1'b1;
            end
            S_DONE: begin
                cmd_done = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_painter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_painter
// Purpose  : Directed self-checking bench for tile_painter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_painter;

    logic       tb_clk;
    logic       nrst;
    logic       diff;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj_code;
    logic       cmd_done;
    logic       busy;
    logic       lcd_csx;
    logic       lcd_dcx;
    logic       lcd_wrx;
    logic [7:0] lcd_dat;

    int n_cmp;
    int n_err;
    int wr_edges;
    int done_cnt;

    tile_painter #(.TILE_PX(20)) dut (
        .clk      (tb_clk),
        .nrst     (nrst),
        .diff     (diff),
        .x        (x),
        .y        (y),
        .obj_code (obj_code),
        .cmd_done (cmd_done),
        .busy     (busy),
        .lcd_csx  (lcd_csx),
        .lcd_dcx  (lcd_dcx),
        .lcd_wrx  (lcd_wrx),
        .lcd_dat  (lcd_dat)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    initial wr_edges = 0;
    always @(posedge lcd_wrx) wr_edges = wr_edges + 1;

    initial done_cnt = 0;
    always @(posedge tb_clk) if (cmd_done === 1'b1) done_cnt = done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // exp_hdr holds b0 in its top byte; abort_k < 0 means no reset mid-transfer.
    task automatic run_tile(input logic [3:0] tx, input logic [3:0] ty, input logic [2:0] code,
                            input logic [87:0] exp_hdr, input logic [15:0] exp_col,
                            input int glitch_k, input int abort_k);
        logic [10:0] dcx_pat;
        int          bad;
        int          wr_base;
        int          done_base;
        logic [7:0]  eb;
        logic        ed;
        dcx_pat   = 11'b01111011110;
        bad       = 0;
        @(negedge tb_clk);
        x = tx; y = ty; obj_code = code; diff = 1'b1;
        wr_base   = wr_edges;
        @(posedge tb_clk);
        #1;
        diff = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 811; k++) begin
            if (k < 11) begin
                eb = exp_hdr[87 - 8*k -: 8];
                ed = dcx_pat[10 - k];
                check($sformatf("hdr_dat%0d", k), {24'd0, lcd_dat}, {24'd0, eb});
                check($sformatf("hdr_dcx%0d", k), {31'd0, lcd_dcx}, {31'd0, ed});
            end else begin
                eb = ((k - 11) % 2 == 0) ? exp_col[15:8] : exp_col[7:0];
                ed = 1'b1;
                if (lcd_dat !== eb || lcd_dcx !== ed) bad++;
            end
            if (lcd_wrx !== 1'b0 || lcd_csx !== 1'b0 || busy !== 1'b1 || cmd_done !== 1'b0) bad++;
            if (k == abort_k) begin
                #2;
                nrst = 1'b0;
                #1;
                check("abort_csx", {31'd0, lcd_csx}, 32'd1);
                check("abort_wrx", {31'd0, lcd_wrx}, 32'd1);
                check("abort_dcx", {31'd0, lcd_dcx}, 32'd1);
                check("abort_dat", {24'd0, lcd_dat}, 32'd0);
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_done", {31'd0, cmd_done}, 32'd0);
                check("abort_bad", bad, 32'd0);
                done_base = done_cnt;
                repeat (3) @(negedge tb_clk);
                nrst = 1'b1;
                repeat (20) @(posedge tb_clk);
                #1;
                check("abort_no_done", done_cnt - done_base, 32'd0);
                check("abort_idle_csx", {31'd0, lcd_csx}, 32'd1);
                return;
            end
            if (k == glitch_k) begin
                x = 4'd3; y = 4'd3; obj_code = 3'd1; diff = 1'b1;
            end
            @(posedge tb_clk);
            #1;
            diff = 1'b0;
            if (lcd_wrx !== 1'b1 || lcd_csx !== 1'b0 || lcd_dat !== eb || lcd_dcx !== ed) bad++;
            @(posedge tb_clk);
            #1;
        end
        check("stream_bad", bad, 32'd0);
        check("done_pulse", {31'd0, cmd_done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_csx", {31'd0, lcd_csx}, 32'd1);
        check("wr_edges", wr_edges - wr_base, 32'd811);
        @(posedge tb_clk);
        #1;
        check("done_drop", {31'd0, cmd_done}, 32'd0);
        check("busy_drop", {31'd0, busy}, 32'd0);
        if (glitch_k >= 0) begin
            repeat (10) @(posedge tb_clk);
            #1;
            check("no_restart_busy", {31'd0, busy}, 32'd0);
            check("no_restart_wr", wr_edges - wr_base, 32'd811);
        end
    endtask

    initial begin
        int wr_base;
        n_cmp = 0; n_err = 0;
        diff = 1'b0; x = 4'd0; y = 4'd0; obj_code = 3'd0;
        nrst = 1'b0;
        #3;
        check("rst_csx", {31'd0, lcd_csx}, 32'd1);
        check("rst_wrx", {31'd0, lcd_wrx}, 32'd1);
        check("rst_dcx", {31'd0, lcd_dcx}, 32'd1);
        check("rst_dat", {24'd0, lcd_dat}, 32'd0);
        check("rst_done", {31'd0, cmd_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge tb_clk);
        nrst = 1'b1;
        repeat (2) @(posedge tb_clk);

        // Tile (0,0), border colour
        run_tile(4'd0, 4'd0, 3'd4, 88'h2A_00_00_00_13_2B_00_00_00_13_2C, 16'h001F, -1, -1);
        // Tile (15,11), apple
        run_tile(4'd15, 4'd11, 3'd3, 88'h2A_01_2C_01_3F_2B_00_DC_00_EF_2C, 16'hF800, -1, -1);
        // Request during transfer (cycle 500 = byte 250) must be ignored
        run_tile(4'd0, 4'd0, 3'd4, 88'h2A_00_00_00_13_2B_00_00_00_13_2C, 16'h001F, 250, -1);

        // Rejected row
        @(negedge tb_clk);
        x = 4'd2; y = 4'd12; obj_code = 3'd1; diff = 1'b1;
        wr_base = wr_edges;
        @(posedge tb_clk);
        #1;
        diff = 1'b0;
        check("rej_done", {31'd0, cmd_done}, 32'd1);
        check("rej_busy", {31'd0, busy}, 32'd1);
        check("rej_csx", {31'd0, lcd_csx}, 32'd1);
        @(posedge tb_clk);
        #1;
        check("rej_done_drop", {31'd0, cmd_done}, 32'd0);
        check("rej_busy_drop", {31'd0, busy}, 32'd0);
        check("rej_wr_edges", wr_edges - wr_base, 32'd0);

        // Reset at byte 300, then a clean tile (2,1) snake body
        run_tile(4'd0, 4'd0, 3'd4, 88'h2A_00_00_00_13_2B_00_00_00_13_2C, 16'h001F, -1, 300);
        run_tile(4'd2, 4'd1, 3'd1, 88'h2A_00_28_00_3B_2B_00_14_00_27_2C, 16'h07E0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
